// File: rtl/booth_r4_serial_mult_hs_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth serial multiplier.
// The package holds the Booth digit encoding, the triplet recoder, the FSM
// state type and the helpers that size the recoded operand and iteration count.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_dig_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} booth_state_e;

  // Radix-4 recoding of the overlapping triplet {x[2i+1], x[2i], x[2i-1]}.
  function automatic booth_dig_e booth_recode(input logic [2:0] t);
    booth_dig_e d;
    case (t)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // Width of x after the 1-bit sign/zero extension, rounded up to even.
  function automatic int booth_xe(input int wx);
    return ((wx + 2) / 2) * 2;
  endfunction

  // Number of Booth digits.
  function automatic int booth_nd(input int wx);
    return booth_xe(wx) / 2;
  endfunction

  // Clock cycles needed to retire every digit.
  function automatic int booth_iter(input int wx, input int dpc);
    return (booth_nd(wx) + dpc - 1) / dpc;
  endfunction

endpackage

// File: rtl/booth_r4_serial_mult_hs_if.sv
// Operand/result handshake bundle for booth_r4_serial_mult_hs.
// master = producer/consumer side, slave = the multiplier.
interface booth_r4_serial_mult_hs_if #(
  parameter int WIDTH_X   = 8,
  parameter int WIDTH_Y   = 8,
  parameter int OUT_WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_signed;
  logic [WIDTH_X-1:0]         in_x;
  logic [WIDTH_Y-1:0]         in_y;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH_X+WIDTH_Y-1:0] prod;
  logic [OUT_WIDTH-1:0]       prod_fix;
  logic                       ovf;

  modport master (
    output in_valid, in_signed, in_x, in_y, out_ready,
    input  in_ready, out_valid, prod, prod_fix, ovf
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, out_ready,
    output in_ready, out_valid, prod, prod_fix, ovf
  );
endinterface

// File: rtl/booth_r4_serial_mult_hs_pp_sel.sv
// One radix-4 partial product: 0, +-y or +-2y of the extended multiplicand,
// sign-extended to the adder width WIDTH_Y+3.
module booth_r4_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH_Y = 8
) (
  input  booth_dig_e          i_dig,
  input  logic [WIDTH_Y:0]    i_y,
  output logic [WIDTH_Y+2:0]  o_pp
);
  logic [WIDTH_Y+2:0] w_y1;
  logic [WIDTH_Y+2:0] w_y2;

  assign w_y1 = {{2{i_y[WIDTH_Y]}}, i_y};
  assign w_y2 = {w_y1[WIDTH_Y+1:0], 1'b0};

  // Digit-driven multiplexer over the four non-zero multiples.
  always_comb begin
    o_pp = '0;
    case (i_dig)
      P1:      o_pp = w_y1;
      P2:      o_pp = w_y2;
      M1:      o_pp = -w_y1;
      M2:      o_pp = -w_y2;
      default: o_pp = '0;
    endcase
  end
endmodule

// File: rtl/booth_r4_serial_mult_hs.sv
// Multi-cycle radix-4 Booth multiplier with valid/ready handshakes.
// Retires DIGITS_PER_CYCLE digits per clock through a combinational chain of
// add/shift stages, then holds the exact product and a fixed-point slice.
// Optional macro SATURATE_EN: clamp prod_fix on overflow instead of wrapping.
module booth_r4_serial_mult_hs
  import booth_pkg::*;
#(
  parameter int WIDTH_X          = 8,
  parameter int WIDTH_Y          = 8,
  parameter int DIGITS_PER_CYCLE = 1,
  parameter int FRAC_BITS        = 0,
  parameter int OUT_WIDTH        = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  booth_r4_serial_mult_hs_if.slave bus
);
  localparam int DPC  = DIGITS_PER_CYCLE;
  localparam int P    = WIDTH_X + WIDTH_Y;
  localparam int AW   = WIDTH_Y + 3;
  localparam int ITER = booth_iter(WIDTH_X, DPC);
  // x is sign-extended to cover every digit the chain retires, so digits past
  // the real operand recode to ZERO and only shift.
  localparam int XP   = 2 * DPC * ITER;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int HI   = FRAC_BITS + OUT_WIDTH;

  booth_state_e r_state, w_state_nxt;
  logic         w_in_ready, w_out_valid, w_accept, w_last;

  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_a;
  logic [XP-1:0]    r_q;
  logic             r_qm;
  logic [WIDTH_Y:0] r_y;
  logic             r_sgn;
  logic [P-1:0]     r_prod;

  logic signed [WIDTH_X:0] w_xe;
  logic [WIDTH_Y:0]        w_ye;
  logic [XP-1:0]           w_xp;

  assign w_xe = {bus.in_signed & bus.in_x[WIDTH_X-1], bus.in_x};
  assign w_ye = {bus.in_signed & bus.in_y[WIDTH_Y-1], bus.in_y};
  assign w_xp = XP'(w_xe);

  // Digit chain: stage g adds its partial product to the running high half
  // and shifts {A,Q} right two bits arithmetically.
  logic [DPC:0][AW-1:0] w_a;
  logic [DPC:0][XP-1:0] w_q;
  logic [P-1:0]         w_full;

  assign w_a[0] = r_a;
  assign w_q[0] = r_q;

  for (genvar g = 0; g < DPC; g++) begin : g_dig
    booth_dig_e    w_dig;
    logic [AW-1:0] w_pp;
    logic [AW-1:0] w_sum;
    logic          w_qm_in;

    if (g == 0) begin : g_first
      assign w_qm_in = r_qm;
    end else begin : g_next
      assign w_qm_in = w_q[g-1][1];
    end

    assign w_dig = booth_recode({w_q[g][1:0], w_qm_in});

    booth_r4_pp_sel #(.WIDTH_Y(WIDTH_Y)) u_pp (
      .i_dig (w_dig),
      .i_y   (r_y),
      .o_pp  (w_pp)
    );

    assign w_sum    = w_a[g] + w_pp;
    assign w_a[g+1] = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_q[g+1] = {w_sum[1:0], w_q[g][XP-1:2]};
  end

  assign w_full = P'({w_a[DPC], w_q[DPC]});
  assign w_last = (r_cnt == CW'(ITER - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; DONE can hand straight over to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_state_nxt = bus.in_valid ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_in_ready & bus.in_valid;

  // Datapath: load on accept, retire digits in RUN, latch the product last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_q    <= '0;
      r_qm   <= 1'b0;
      r_y    <= '0;
      r_sgn  <= 1'b0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_q    <= w_xp;
      r_qm   <= 1'b0;
      r_y    <= w_ye;
      r_sgn  <= bus.in_signed;
    end else if (r_state == RUN) begin
      r_cnt  <= r_cnt + 1'b1;
      r_a    <= w_a[DPC];
      r_q    <= w_q[DPC];
      r_qm   <= w_q[DPC-1][1];
      if (w_last) r_prod <= w_full;
    end
  end

  // Fixed-point slice and overflow of the discarded upper bits.
  logic [OUT_WIDTH-1:0] w_slice;
  logic                 w_ovf;

  assign w_slice = r_prod[HI-1:FRAC_BITS];

  if (HI < P) begin : g_ovf
    logic [P-HI-1:0] w_up;
    assign w_up  = r_prod[P-1:HI];
    assign w_ovf = r_sgn ? (w_up != {(P-HI){w_slice[OUT_WIDTH-1]}}) : (|w_up);
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

`ifdef SATURATE_EN
  logic [OUT_WIDTH-1:0] w_sat;

  // Clamp value: signed follows the product sign, unsigned goes to all ones.
  always_comb begin
    w_sat = '1;
    if (r_sgn) w_sat = r_prod[P-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  assign bus.prod_fix = w_ovf ? w_sat : w_slice;
`else
  assign bus.prod_fix = w_slice;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.prod      = r_prod;
  assign bus.ovf       = w_ovf;

endmodule

// File: tb/tb_booth_r4_serial_mult_hs.sv
// Bench for booth_r4_serial_mult_hs: four instances (8x8/1, 16x16 with 1, 2
// and 4 digits per cycle) checked against an integer-arithmetic model.
module tb_booth_r4_serial_mult_hs;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  booth_r4_serial_mult_hs_if #(.WIDTH_X(8),  .WIDTH_Y(8),  .OUT_WIDTH(8))  if0();
  booth_r4_serial_mult_hs_if #(.WIDTH_X(16), .WIDTH_Y(16), .OUT_WIDTH(16)) if1();
  booth_r4_serial_mult_hs_if #(.WIDTH_X(16), .WIDTH_Y(16), .OUT_WIDTH(16)) if2();
  booth_r4_serial_mult_hs_if #(.WIDTH_X(16), .WIDTH_Y(16), .OUT_WIDTH(16)) if3();

  booth_r4_serial_mult_hs #(.WIDTH_X(8), .WIDTH_Y(8), .DIGITS_PER_CYCLE(1),
    .FRAC_BITS(0), .OUT_WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  booth_r4_serial_mult_hs #(.WIDTH_X(16), .WIDTH_Y(16), .DIGITS_PER_CYCLE(1),
    .FRAC_BITS(12), .OUT_WIDTH(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  booth_r4_serial_mult_hs #(.WIDTH_X(16), .WIDTH_Y(16), .DIGITS_PER_CYCLE(2),
    .FRAC_BITS(12), .OUT_WIDTH(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  booth_r4_serial_mult_hs #(.WIDTH_X(16), .WIDTH_Y(16), .DIGITS_PER_CYCLE(4),
    .FRAC_BITS(12), .OUT_WIDTH(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  function automatic int lat_exp(input int d);
    case (d)
      0:       return 5;
      1:       return 9;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] g_prod(input int d);
    case (d)
      0:       return {16'h0, if0.prod};
      1:       return if1.prod;
      2:       return if2.prod;
      default: return if3.prod;
    endcase
  endfunction

  function automatic logic [15:0] g_fix(input int d);
    case (d)
      0:       return {8'h0, if0.prod_fix};
      1:       return if1.prod_fix;
      2:       return if2.prod_fix;
      default: return if3.prod_fix;
    endcase
  endfunction

  function automatic logic g_ovf(input int d);
    case (d)
      0:       return if0.ovf;
      1:       return if1.ovf;
      2:       return if2.ovf;
      default: return if3.ovf;
    endcase
  endfunction

  function automatic logic g_ov(input int d);
    case (d)
      0:       return if0.out_valid;
      1:       return if1.out_valid;
      2:       return if2.out_valid;
      default: return if3.out_valid;
    endcase
  endfunction

  function automatic logic g_rdy(input int d);
    case (d)
      0:       return if0.in_ready;
      1:       return if1.in_ready;
      2:       return if2.in_ready;
      default: return if3.in_ready;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic s,
                        input logic [15:0] x, input logic [15:0] y);
    case (d)
      0: begin if0.in_valid = v; if0.in_signed = s; if0.in_x = x[7:0]; if0.in_y = y[7:0]; end
      1: begin if1.in_valid = v; if1.in_signed = s; if1.in_x = x; if1.in_y = y; end
      2: begin if2.in_valid = v; if2.in_signed = s; if2.in_x = x; if2.in_y = y; end
      default: begin if3.in_valid = v; if3.in_signed = s; if3.in_x = x; if3.in_y = y; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic r);
    case (d)
      0:       if0.out_ready = r;
      1:       if1.out_ready = r;
      2:       if2.out_ready = r;
      default: if3.out_ready = r;
    endcase
  endtask

  // Reference: exact integer product, then the slice as a shifted value
  // checked against the representable range of the mode.
  function automatic void model(input int d, input bit s, input logic [15:0] x,
                                input logic [15:0] y, output logic [31:0] p,
                                output logic [15:0] f, output bit ov);
    int     w, fr, ow;
    longint xv, yv, pv, sl, mx, mn, r;
    w  = (d == 0) ? 8 : 16;
    fr = (d == 0) ? 0 : 12;
    ow = (d == 0) ? 8 : 16;
    xv = longint'(x) & ((64'sd1 << w) - 1);
    yv = longint'(y) & ((64'sd1 << w) - 1);
    if (s && xv >= (64'sd1 << (w - 1))) xv = xv - (64'sd1 << w);
    if (s && yv >= (64'sd1 << (w - 1))) yv = yv - (64'sd1 << w);
    pv = xv * yv;
    p  = 32'(pv & ((64'sd1 << (2 * w)) - 1));
    sl = pv >>> fr;
    if (s) begin mx = (64'sd1 << (ow - 1)) - 1; mn = -(64'sd1 << (ow - 1)); end
    else   begin mx = (64'sd1 << ow) - 1;       mn = 0; end
    ov = (sl > mx) || (sl < mn);
    r  = sl;
`ifdef SATURATE_EN
    if (ov) r = (sl > mx) ? mx : mn;
`endif
    f = 16'(r & ((64'sd1 << ow) - 1));
  endfunction

  task automatic issue(input int d, input bit s, input logic [15:0] x, input logic [15:0] y);
    int n;
    set_in(d, 1'b1, s, x, y);
    #1;
    n = 0;
    while (!g_rdy(d) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL accept_timeout dut%0d in_ready=%b want 1", d, g_rdy(d)); end
    @(posedge clk); #1;
    set_in(d, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!g_ov(d) && lat < 50);
  endtask

  task automatic consume(input int d);
    set_ordy(d, 1'b1);
    @(posedge clk); #1;
    set_ordy(d, 1'b0);
  endtask

  task automatic run_op(input int d, input bit s, input logic [15:0] x, input logic [15:0] y,
                        output logic [31:0] p, output logic [15:0] f, output bit ov, output int lat);
    set_ordy(d, 1'b0);
    issue(d, s, x, y);
    wait_done(d, lat);
    p  = g_prod(d);
    f  = g_fix(d);
    ov = g_ovf(d);
    consume(d);
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 4; d++) begin
      checks++; if (g_ov(d) !== 1'b0)    begin errors++; $display("FAIL rst_out_valid dut%0d got %b want 0", d, g_ov(d)); end
      checks++; if (g_rdy(d) !== 1'b1)   begin errors++; $display("FAIL rst_in_ready dut%0d got %b want 1", d, g_rdy(d)); end
      checks++; if (g_prod(d) !== 32'h0) begin errors++; $display("FAIL rst_prod dut%0d got %h want 0", d, g_prod(d)); end
      checks++; if (g_fix(d) !== 16'h0)  begin errors++; $display("FAIL rst_prod_fix dut%0d got %h want 0", d, g_fix(d)); end
      checks++; if (g_ovf(d) !== 1'b0)   begin errors++; $display("FAIL rst_ovf dut%0d got %b want 0", d, g_ovf(d)); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_basic();
    logic [31:0] p; logic [15:0] f; bit ov; int lat;
    run_op(0, 1'b1, 16'h0080, 16'h0080, p, f, ov, lat);
    checks++; if (p !== 32'h4000) begin errors++; $display("FAIL min_min_prod got %h want 4000", p); end
    checks++; if (lat !== 5)      begin errors++; $display("FAIL min_min_latency got %0d want 5", lat); end
    run_op(0, 1'b1, 16'h0007, 16'h00FD, p, f, ov, lat);
    checks++; if (p !== 32'hFFEB) begin errors++; $display("FAIL 7_x_m3_prod got %h want ffeb", p); end
    checks++; if (f !== 16'h00EB) begin errors++; $display("FAIL 7_x_m3_fix got %h want eb", f); end
    checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL 7_x_m3_ovf got %b want 0", ov); end
  endtask

  task automatic test_unsigned();
    logic [31:0] p; logic [15:0] f; bit ov; int lat;
    run_op(0, 1'b0, 16'h00FF, 16'h00FF, p, f, ov, lat);
    checks++; if (p !== 32'hFE01) begin errors++; $display("FAIL umax_prod got %h want fe01", p); end
    checks++; if (ov !== 1'b1)    begin errors++; $display("FAIL umax_ovf got %b want 1", ov); end
    run_op(0, 1'b1, 16'h00FF, 16'h00FF, p, f, ov, lat);
    checks++; if (p !== 32'h0001) begin errors++; $display("FAIL m1_m1_prod got %h want 0001", p); end
    checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL m1_m1_ovf got %b want 0", ov); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p0; int lat; bit stable;
    set_ordy(0, 1'b0);
    issue(0, 1'b1, 16'h0005, 16'h00F9);
    wait_done(0, lat);
    p0 = g_prod(0);
    checks++; if (p0 !== 32'hFFDD) begin errors++; $display("FAIL hold_prod got %h want ffdd", p0); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (g_ov(0) !== 1'b1 || g_prod(0) !== 32'hFFDD || g_rdy(0) !== 1'b0) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", stable); end
    set_ordy(0, 1'b1);
    set_in(0, 1'b1, 1'b0, 16'h00C8, 16'h0003);
    #1;
    checks++; if (g_rdy(0) !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", g_rdy(0)); end
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
    checks++; if (g_ov(0) !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_drop got %b want 0", g_ov(0)); end
    wait_done(0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
    checks++; if (g_prod(0) !== 32'h0258) begin errors++; $display("FAIL b2b_prod got %h want 0258", g_prod(0)); end
    consume(0);
  endtask

  task automatic test_fixed();
    logic [31:0] p; logic [15:0] f; bit ov; int lat;
    logic [15:0] f_want;
`ifdef SATURATE_EN
    f_want = 16'h7FFF;
`else
    f_want = 16'h9000;
`endif
    run_op(1, 1'b1, 16'h2000, 16'h2000, p, f, ov, lat);
    checks++; if (f !== 16'h4000) begin errors++; $display("FAIL fix_2000_slice got %h want 4000", f); end
    checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL fix_2000_ovf got %b want 0", ov); end
    checks++; if (lat !== 9)      begin errors++; $display("FAIL fix_latency got %0d want 9", lat); end
    run_op(1, 1'b1, 16'h3000, 16'h3000, p, f, ov, lat);
    checks++; if (ov !== 1'b1)    begin errors++; $display("FAIL fix_3000_ovf got %b want 1", ov); end
    checks++; if (f !== f_want)   begin errors++; $display("FAIL fix_3000_slice got %h want %h", f, f_want); end
    checks++; if (p !== 32'h09000000) begin errors++; $display("FAIL fix_3000_prod got %h want 09000000", p); end
  endtask

  task automatic test_random();
    logic [31:0] p, ep; logic [15:0] f, ef; bit ov, eov; int lat;
    logic [15:0] x, y; bit s;
    for (int d = 2; d < 4; d++) begin
      for (int i = 0; i < 1000; i++) begin
        case (i)
          0:       begin s = 1'b1; x = 16'h8000; y = 16'h8000; end
          1:       begin s = 1'b0; x = 16'hFFFF; y = 16'hFFFF; end
          2:       begin s = 1'b1; x = 16'h8000; y = 16'h7FFF; end
          default: begin s = 1'($urandom_range(0, 1)); x = 16'($urandom); y = 16'($urandom); end
        endcase
        run_op(d, s, x, y, p, f, ov, lat);
        model(d, s, x, y, ep, ef, eov);
        checks++; if (p !== ep)   begin errors++; $display("FAIL rnd_prod dut%0d s=%0d x=%h y=%h got %h want %h", d, s, x, y, p, ep); end
        checks++; if (f !== ef)   begin errors++; $display("FAIL rnd_fix dut%0d s=%0d x=%h y=%h got %h want %h", d, s, x, y, f, ef); end
        checks++; if (ov !== eov) begin errors++; $display("FAIL rnd_ovf dut%0d s=%0d x=%h y=%h got %b want %b", d, s, x, y, ov, eov); end
        checks++; if (lat !== lat_exp(d)) begin errors++; $display("FAIL rnd_latency dut%0d got %0d want %0d", d, lat, lat_exp(d)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p, ep; logic [15:0] f, ef; bit ov, eov; int lat; bit stale;
    set_ordy(0, 1'b0);
    issue(0, 1'b1, 16'h0033, 16'h0044);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #3;
    checks++; if (g_ov(0) !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", g_ov(0)); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (g_rdy(0) !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", g_rdy(0)); end
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (g_ov(0) !== 1'b0) stale = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale_result got %b want 0", stale); end
    run_op(0, 1'b1, 16'h00B5, 16'h0013, p, f, ov, lat);
    model(0, 1'b1, 16'h00B5, 16'h0013, ep, ef, eov);
    checks++; if (p !== ep)  begin errors++; $display("FAIL midrst_next_prod got %h want %h", p, ep); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_next_latency got %0d want 5", lat); end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      set_in(d, 1'b0, 1'b0, 16'h0, 16'h0);
      set_ordy(d, 1'b0);
    end
    test_reset();
    test_signed_basic();
    test_unsigned();
    test_back_to_back();
    test_fixed();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
